credit_relay_tx: RTL and testbench

- Transmitter end of a credit-based inter-slot relay link.
- Accepts words through the standard FIFO write interface (if_full_n / if_write / if_din) and forwards them across LEVEL pipeline register stages toward a remote receiver buffer.
- Send eligibility comes from a local credit counter, not from a delayed almost-full signal. The remote end returns one credit per word it consumes, and the return also crosses LEVEL register stages.
- Used when a floorplanned channel is too long for an almost-full grace margin.

---
 rtl/credit_relay_tx.sv | 128 ++++++++++++
 tb/tb_credit_relay_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_relay_tx.sv
// credit_relay_tx: transmitter end of a credit-based relay link.
// Ports: clk/reset; FIFO write side if_full_n/if_write_ce/if_write/if_din;
// link_valid/link_data forward path; link_credit return path;
// credit_count and sticky credit_err status.
module credit_relay_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int LEVEL      = 2,
    parameter int CREDITS    = 8,
    parameter int CNT_WIDTH  = $clog2(CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  link_valid,
    output logic [DATA_WIDTH-1:0] link_data,
    input  logic                  link_credit,
    output logic [CNT_WIDTH-1:0]  credit_count,
    output logic                  credit_err
);

    localparam logic [CNT_WIDTH-1:0] CRED_MAX = CNT_WIDTH'(CREDITS);
    localparam logic [CNT_WIDTH-1:0] CRED_ONE = CNT_WIDTH'(1);

    logic [1:0]                 occ_q, occ_d;
    logic [1:0][DATA_WIDTH-1:0] buf_q, buf_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic                       accept;
    logic                       send;
    logic                       credit_r;
    logic [1:0]                 slot;

    assign if_full_n    = (occ_q != 2'd2);
    assign accept       = if_write & if_write_ce & if_full_n;
    assign send         = (occ_q != 2'd0) & (cnt_q != '0);
    assign credit_count = cnt_q;
    assign credit_err   = err_q;

    // Entry 0 is always the head; a pop shifts entry 1 down, and the
    // incoming word lands in the first free slot after that pop.
    assign slot = occ_q - {1'b0, send};

    always_comb begin
        buf_d = buf_q;
        occ_d = occ_q + {1'b0, accept} - {1'b0, send};
        if (send) begin
            buf_d[0] = buf_q[1];
        end
        if (accept) begin
            if (slot == 2'd0) begin
                buf_d[0] = if_din;
            end else begin
                buf_d[1] = if_din;
            end
        end
    end

    // Counter saturates at CREDITS; an extra returned credit is flagged.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (send && !credit_r) begin
            cnt_d = cnt_q - CRED_ONE;
        end else if (!send && credit_r) begin
            if (cnt_q == CRED_MAX) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CRED_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= 2'd0;
            cnt_q <= CRED_MAX;
            err_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    if (LEVEL == 0) begin : g_direct
        assign link_valid = send;
        assign link_data  = buf_q[0];
        assign credit_r   = link_credit;
    end else begin : g_pipe
        logic [LEVEL-1:0]                 vld_q;
        logic [LEVEL-1:0]                 crd_q;
        logic [LEVEL-1:0][DATA_WIDTH-1:0] dat_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= '0;
                crd_q <= '0;
            end else begin
                vld_q[0] <= send;
                crd_q[0] <= link_credit;
                for (int i = 1; i < LEVEL; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    crd_q[i] <= crd_q[i-1];
                end
            end
        end

        // Payload stages carry no reset; only the valid bits qualify them.
        always_ff @(posedge clk) begin
            dat_q[0] <= buf_q[0];
            for (int i = 1; i < LEVEL; i++) begin
                dat_q[i] <= dat_q[i-1];
            end
        end

        assign link_valid = vld_q[LEVEL-1];
        assign link_data  = dat_q[LEVEL-1];
        assign credit_r   = crd_q[LEVEL-1];
    end

endmodule

// File: tb/tb_credit_relay_tx.sv
// tb_credit_relay_tx: directed table, hand sequences and random traffic
// against a queue-based model of the credit relay transmitter.
module tb_credit_relay_tx;

    localparam int DW = 32;
    localparam int LV = 2;
    localparam int CR = 8;
    localparam int CW = $clog2(CR + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          if_full_n;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          link_valid;
    logic [DW-1:0] link_data;
    logic          link_credit;
    logic [CW-1:0] credit_count;
    logic          credit_err;

    credit_relay_tx #(
        .DATA_WIDTH(DW),
        .LEVEL(LV),
        .CREDITS(CR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_full_n(if_full_n),
        .if_write_ce(if_write_ce),
        .if_write(if_write),
        .if_din(if_din),
        .link_valid(link_valid),
        .link_data(link_data),
        .link_credit(link_credit),
        .credit_count(credit_count),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: word queue, credit integer, and cycle-indexed event rings.
    logic [DW-1:0] mq[$];
    int            mcred;
    bit            merr;
    bit            ev[16];
    logic [DW-1:0] ed[16];
    bit            cq[16];
    int            cnum = 0;
    bit            known = 0;

    typedef struct {
        bit          wr;
        logic [31:0] din;
        bit          cr;
        bit          e_fn;
        bit          e_v;
        logic [31:0] e_d;
        int          e_cnt;
        bit          e_err;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cnum);
        end
    endtask

    task automatic mcheck();
        int s;
        s = cnum % 16;
        if (known) begin
            chk("m_full_n", if_full_n, 64'(mq.size() != 2));
            chk("m_valid", link_valid, 64'(ev[s]));
            if (ev[s]) chk("m_data", link_data, ed[s]);
            chk("m_count", credit_count, 64'(mcred));
            chk("m_err", credit_err, 64'(merr));
        end
    endtask

    task automatic cyc(input bit r, input bit w, input bit e,
                       input logic [DW-1:0] d, input bit c);
        int s;
        bit acc;
        bit snd;
        bit rr;
        mcheck();
        reset       = r;
        if_write    = w;
        if_write_ce = e;
        if_din      = d;
        link_credit = c;
        s = cnum % 16;
        if (r) begin
            mq.delete();
            mcred = CR;
            merr  = 0;
            for (int i = 0; i < 16; i++) begin
                ev[i] = 0;
                cq[i] = 0;
            end
            known = 1;
        end else begin
            acc = w && e && (mq.size() != 2);
            snd = (mq.size() != 0) && (mcred != 0);
            cq[(cnum + LV) % 16] = cq[(cnum + LV) % 16] | c;
            rr = cq[s];
            ev[s] = 0;
            cq[s] = 0;
            if (snd) begin
                ev[(cnum + LV) % 16] = 1;
                ed[(cnum + LV) % 16] = mq.pop_front();
            end
            mcred = mcred - int'(snd) + int'(rr);
            if (mcred > CR) begin
                mcred = CR;
                merr  = 1;
            end
            if (acc) mq.push_back(d);
        end
        cnum++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] obs[$];
        int first;
        logic [DW-1:0] fdat;
        int pending;
        bit c;

        reset       = 1'b1;
        if_write    = 1'b0;
        if_write_ce = 1'b0;
        if_din      = '0;
        link_credit = 1'b0;
        @(posedge clk);
        #1;

        // Reset, single word, returned credit, then overflow.
        tv[0]  = '{0, 32'h0,  0, 1, 0, 32'h0,  8, 0};
        tv[1]  = '{0, 32'h0,  0, 1, 0, 32'h0,  8, 0};
        tv[2]  = '{1, 32'hA5, 0, 1, 0, 32'h0,  8, 0};
        tv[3]  = '{0, 32'h0,  0, 1, 0, 32'h0,  8, 0};
        tv[4]  = '{0, 32'h0,  0, 1, 0, 32'h0,  7, 0};
        tv[5]  = '{0, 32'h0,  0, 1, 1, 32'hA5, 7, 0};
        tv[6]  = '{0, 32'h0,  1, 1, 0, 32'h0,  7, 0};
        tv[7]  = '{0, 32'h0,  0, 1, 0, 32'h0,  7, 0};
        tv[8]  = '{0, 32'h0,  0, 1, 0, 32'h0,  7, 0};
        tv[9]  = '{0, 32'h0,  1, 1, 0, 32'h0,  8, 0};
        tv[10] = '{0, 32'h0,  0, 1, 0, 32'h0,  8, 0};
        tv[11] = '{0, 32'h0,  0, 1, 0, 32'h0,  8, 0};
        tv[12] = '{0, 32'h0,  0, 1, 0, 32'h0,  8, 1};
        tv[13] = '{0, 32'h0,  0, 1, 0, 32'h0,  8, 1};

        repeat (3) cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < 14; i++) begin
            chk("t_full_n", if_full_n, 64'(tv[i].e_fn));
            chk("t_valid", link_valid, 64'(tv[i].e_v));
            if (tv[i].e_v) chk("t_data", link_data, tv[i].e_d);
            chk("t_count", credit_count, 64'(tv[i].e_cnt));
            chk("t_err", credit_err, 64'(tv[i].e_err));
            cyc(0, tv[i].wr, 1, tv[i].din, tv[i].cr);
        end

        // Credit exhaustion: 10 writes, no returns.
        cyc(1, 0, 0, '0, 0);
        for (int k = 0; k < 20; k++) begin
            if (link_valid) obs.push_back(link_data);
            cyc(0, k < 10, 1, DW'(k + 1), 0);
        end
        chk("exh_pulses", 64'(obs.size()), 64'(CR));
        for (int i = 0; i < obs.size(); i++)
            chk("exh_data", obs[i], 64'(i + 1));
        chk("exh_count", credit_count, 0);
        chk("exh_full_n", if_full_n, 0);
        cyc(0, 0, 1, '0, 1);
        first = -1;
        fdat  = '0;
        for (int k = 1; k <= 10; k++) begin
            if (link_valid && first < 0) begin
                first = k;
                fdat  = link_data;
            end
            cyc(0, 0, 1, '0, 0);
        end
        chk("exh_lat", 64'(first), 64'(2 * LV + 1));
        chk("exh_word", fdat, 9);
        chk("exh_count2", credit_count, 0);
        chk("exh_full_n2", if_full_n, 1);

        // Steady stream with one credit returned every cycle.
        cyc(1, 0, 0, '0, 0);
        for (int k = 0; k < 40; k++) begin
            chk("st_full_n", if_full_n, 1);
            if (k >= 2) chk("st_count", credit_count, 7);
            if (k >= 3) begin
                chk("st_valid", link_valid, 1);
                chk("st_data", link_data, 64'(k - 3));
            end
            cyc(0, 1, 1, DW'(k), 1);
        end

        // Reset with words buffered, in flight, and a credit in flight.
        cyc(1, 0, 0, '0, 0);
        for (int k = 0; k < 10; k++) cyc(0, 1, 1, DW'(100 + k), k == 9);
        cyc(1, 0, 0, '0, 0);
        for (int k = 0; k < 12; k++) begin
            chk("rs_valid", link_valid, 0);
            chk("rs_count", credit_count, 64'(CR));
            chk("rs_full_n", if_full_n, 1);
            chk("rs_err", credit_err, 0);
            cyc(0, 0, 1, '0, 0);
        end

        // Random traffic with a remote end that returns credits late.
        cyc(1, 0, 0, '0, 0);
        pending = 0;
        for (int k = 0; k < 1500; k++) begin
            if (ev[cnum % 16]) pending++;
            c = (pending > 0) && ($urandom % 3 != 0);
            if (c) pending--;
            if ($urandom % 500 == 0) begin
                pending = 0;
                cyc(1, 0, 0, '0, 0);
            end else begin
                cyc(0, $urandom % 4 != 0, $urandom % 8 != 0, $urandom, c);
            end
        end
        mcheck();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
